// File: rtl/dbus_master.sv
// dbus_master: data-memory bus initiator running one load/store bus cycle per pipeline request
//   clk, rst (async active-low) | req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata: request
//   resp_valid/resp_err/resp_rdata: one-cycle response | DAD/MREQ/WRITE/SIZE/DDT/ACKD_n: memory bus
module dbus_master #(
  parameter int BIT_WIDTH   = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CW-1:0] LIM = CW'(ACK_TIMEOUT - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [BIT_WIDTH-1:0] wdata_q, ld;
  logic sgn_q, acc, mis, tmo;
  assign req_ready  = state != BUS && rst;
  assign acc        = req_valid && req_ready;
  assign mis        = (req_size == 2'b00 && req_addr[1:0] != 2'b00) || (req_size == 2'b01 && req_addr[0]);
  // cnt holds the number of unacked BUS edges already seen, so the limit hits on the ACK_TIMEOUT-th edge
  assign tmo        = ACK_TIMEOUT != 0 && cnt == LIM;
  assign MREQ       = state == BUS;
  assign resp_valid = state == RESP;
  assign DDT        = MREQ && WRITE ? wdata_q : 'z;
  always_comb begin
    ld  = WRITE ? '0 :
          SIZE == 2'b00 ? DDT :
          SIZE == 2'b01 ? {{(BIT_WIDTH-16){sgn_q & DDT[15]}}, DDT[15:0]} :
                          {{(BIT_WIDTH-8){sgn_q & DDT[7]}}, DDT[7:0]};
    nxt = state != BUS ? (acc ? (mis ? RESP : BUS) : IDLE) :
          (!ACKD_n || tmo) ? RESP : BUS;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      DAD        <= '0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
      wdata_q    <= '0;
      sgn_q      <= 1'b0;
      cnt        <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        cnt <= '0;
        if (mis) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          DAD     <= req_addr;
          WRITE   <= req_write;
          SIZE    <= req_size;
          wdata_q <= req_wdata;
          sgn_q   <= req_signed;
        end
      end
      if (state == BUS) begin
        if (!ACKD_n) begin
          resp_err   <= 1'b0;
          resp_rdata <= ld;
        end else if (tmo) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_dbus_master.sv
// tb_dbus_master: randomized scoreboard bench for dbus_master with a behavioural memory responder
module tb_dbus_master;
  typedef struct {logic w; logic [1:0] sz; logic [31:0] a; logic [31:0] wd; int dly;} bus_t;
  typedef struct {logic err; logic [31:0] rd;} exp_t;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_write = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, MREQ, WRITE;
  logic [31:0] resp_rdata, DAD;
  logic [1:0] SIZE;
  logic ACKD_n = 1, rd_en = 0;
  logic [31:0] rd_drv = 0;
  wire [31:0] DDT;
  assign DDT = rd_en ? rd_drv : 'z;
  logic [7:0] dev_mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  bus_t bus_q[$];
  exp_t exp_q[$];
  int total = 0, bad = 0;
  dbus_master #(.BIT_WIDTH(32), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .DAD(DAD),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DDT(DDT), .ACKD_n(ACKD_n));
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_load(input int i, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'b00) v = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
    else if (sz == 2'b01) begin
      v = {16'h0, ref_mem[i], ref_mem[i+1]};
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = {24'h0, ref_mem[i]};
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction
  task automatic model_store(input int i, input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]} = wd;
    else if (sz == 2'b01) {ref_mem[i], ref_mem[i+1]} = wd[15:0];
    else ref_mem[i] = wd[7:0];
  endtask
  // dly: responder acks in the dly-th MREQ cycle; 0 means never (the 4-cycle timeout fires)
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input bit want);
    bus_t e;
    exp_t x;
    logic mis;
    int n;
    mis = (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    x.err = mis || dly == 0;
    x.rd = 0;
    if (!mis) begin
      e.w = w; e.sz = sz; e.a = a; e.wd = wd; e.dly = dly;
      bus_q.push_back(e);
      if (dly != 0 && w) model_store(int'(a[9:0]), sz, wd);
      if (dly != 0 && !w) x.rd = model_load(int'(a[9:0]), sz, sg);
    end
    if (want) exp_q.push_back(x);
    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL accept_timeout req_ready=%b", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + bus_q.size(), 0);
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp err=%b rdata=%h", resp_err, resp_rdata);
      end else begin
        x = exp_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(x.err));
        check("resp_rdata", resp_rdata, x.rd);
      end
    end
  end
  initial begin
    bus_t cur;
    int bus_cyc = 0;
    int i;
    forever begin
      @(posedge clk);
      #1 ACKD_n = 1; rd_en = 0;
      if (!rst) begin
        bus_cyc = 0;
        bus_q.delete();
      end else if (MREQ) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mreq DAD=%h", DAD);
        end else begin
          cur = bus_q[0];
          bus_cyc++;
          check("bus_dad", DAD, cur.a);
          check("bus_write", 32'(WRITE), 32'(cur.w));
          check("bus_size", 32'(SIZE), 32'(cur.sz));
          if (cur.w) check("bus_ddt", DDT, cur.wd);
          if (cur.dly != 0 && bus_cyc == cur.dly) begin
            ACKD_n = 0;
            i = int'(cur.a[9:0]);
            if (cur.w) begin
              if (cur.sz == 2'b00) {dev_mem[i], dev_mem[i+1], dev_mem[i+2], dev_mem[i+3]} = DDT;
              else if (cur.sz == 2'b01) {dev_mem[i], dev_mem[i+1]} = DDT[15:0];
              else dev_mem[i] = DDT[7:0];
            end else begin
              rd_drv = $urandom;
              if (cur.sz == 2'b00) rd_drv = {dev_mem[i], dev_mem[i+1], dev_mem[i+2], dev_mem[i+3]};
              else if (cur.sz == 2'b01) rd_drv[15:0] = {dev_mem[i], dev_mem[i+1]};
              else rd_drv[7:0] = dev_mem[i];
              rd_en = 1;
            end
          end
        end
      end else if (bus_cyc > 0) begin
        check("mreq_cycles", bus_cyc, cur.dly != 0 ? cur.dly : 4);
        void'(bus_q.pop_front());
        bus_cyc = 0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    for (int k = 0; k < 1024; k++) begin
      dev_mem[k] = 8'(k * 37 + 11);
      ref_mem[k] = 8'(k * 37 + 11);
    end
    #3;
    check("rst_mreq", 32'(MREQ), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_bus", {DAD[29:0], WRITE, |SIZE}, 0);
    check("rst_rdata", resp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 1);
    {dev_mem[256], dev_mem[257], dev_mem[258], dev_mem[259]} = 32'hDEADBEEF;
    {ref_mem[256], ref_mem[257], ref_mem[258], ref_mem[259]} = 32'hDEADBEEF;
    issue(0, 2'b00, 0, 32'h100, 0, 1, 1);
    check("lat_mreq_n1", 32'(MREQ), 1);
    @(negedge clk);
    check("lat_valid_n1", 32'(resp_valid), 0);
    @(negedge clk);
    check("lat_valid_n2", 32'(resp_valid), 1);
    check("lat_word_rdata", resp_rdata, 32'hDEADBEEF);
    drain();
    dev_mem[259] = 8'h80;
    ref_mem[259] = 8'h80;
    issue(0, 2'b10, 1, 32'h103, 0, 1, 1);
    issue(0, 2'b10, 0, 32'h103, 0, 2, 1);
    issue(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 1, 1);
    drain();
    check("mem_202", 32'(dev_mem[514]), 32'hAB);
    check("mem_203", 32'(dev_mem[515]), 32'hCD);
    issue(0, 2'b00, 0, 32'h101, 0, 1, 1);
    issue(0, 2'b01, 1, 32'h203, 0, 1, 1);
    issue(0, 2'b00, 0, 32'h100, 0, 0, 1);
    issue(0, 2'b00, 0, 32'h100, 0, 4, 1);
    issue(1, 2'b11, 0, 32'h17, 32'hFFFFFF5A, 3, 1);
    issue(0, 2'b11, 1, 32'h17, 0, 1, 1);
    drain();
    for (int k = 0; k < 160; k++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1019));
      if ($urandom_range(0, 3) != 0) a[1:0] = sz == 2'b00 ? 2'b00 : sz == 2'b01 ? {a[1], 1'b0} : a[1:0];
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(1, 3), 1);
    end
    drain();
    issue(1, 2'b00, 0, 32'h300, 32'hCAFEF00D, 1, 1);
    issue(0, 2'b00, 0, 32'h300, 0, 3, 0);
    check("b2b_mreq", 32'(MREQ), 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    check("async_mreq_drop", 32'(MREQ), 0);
    check("ready_in_rst", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("ready_post_rst", 32'(req_ready), 1);
    check("no_resp_post_rst", 32'(resp_valid), 0);
    repeat (3) @(negedge clk);
    drain();
    issue(0, 2'b00, 0, 32'h300, 0, 2, 1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
